score_board: RTL and testbench

- Parametrised score keeper and display driver for N players. Successor to the fixed 2-player, single-hex-digit score path.
- Counts points per player in BCD and detects the win threshold.
- Latches game-over and the winner index, and drives active-low 7-segment digits per player.
- In the game-over state, blinks the winner's digits.
- Sits between the game datapath (point pulses, new-game request) and the board HEX displays and control FSM (gameover).

---
 rtl/pong_pkg.sv | 34 +++
 rtl/score_board_if.sv | 26 ++
 rtl/score_bcd_counter.sv | 47 ++++
 rtl/score_board.sv | 147 ++++++++++++++
 tb/tb_score_board.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared types, constants and helpers for the score keeper: FSM state, 7-segment table,
// BCD conversion and winner-index width.
package pong_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  // Active-low segment patterns {g,f,e,d,c,b,a}, same as the board hex decoder.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int unsigned winner_width(int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] bcd_to_seg(logic [3:0] d);
    if (d <= 4'd9) return SEG_DIGIT[d];
    return SEG_BLANK;
  endfunction

  function automatic int unsigned bcd_to_int(logic [15:0] bcd);
    int unsigned r;
    r = 0;
    for (int i = 3; i >= 0; i--) begin
      r = r * 10 + 32'(bcd[i*4 +: 4]);
    end
    return r;
  endfunction

endpackage

// File: rtl/score_board_if.sv
// Game-datapath / display side of the score keeper: point pulses and new-game request in,
// game status, packed BCD scores and active-low segment digits out.
interface score_board_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned DIGITS      = 2
);
  localparam int unsigned WW = pong_pkg::winner_width(NUM_PLAYERS);

  logic [NUM_PLAYERS-1:0]          point;
  logic                            new_game;
  logic                            gameover;
  logic [WW-1:0]                   winner;
  logic [NUM_PLAYERS*DIGITS*4-1:0] scores;
  logic [NUM_PLAYERS*DIGITS*7-1:0] segments;

  modport master (
    output point, new_game,
    input  gameover, winner, scores, segments
  );

  modport slave (
    input  point, new_game,
    output gameover, winner, scores, segments
  );

endinterface

// File: rtl/score_bcd_counter.sv
// Per-player saturating BCD score counter; clr wins over inc.
module score_bcd_counter #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clr,
  input  logic                inc,
  output logic [DIGITS*4-1:0] value
);

  logic [DIGITS*4-1:0] value_q, value_d;
  logic                all_nines;
  logic                carry;

  always_comb begin
    value_d   = value_q;
    all_nines = 1'b1;
    carry     = 1'b1;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (value_q[d*4 +: 4] != 4'd9) all_nines = 1'b0;
    end
    if (clr) begin
      value_d = '0;
    end else if (inc && !all_nines) begin
      // Ripple carry upward: each 9 rolls to 0 until a digit absorbs the +1.
      for (int d = 0; d < int'(DIGITS); d++) begin
        if (carry) begin
          if (value_q[d*4 +: 4] == 4'd9) begin
            value_d[d*4 +: 4] = 4'd0;
          end else begin
            value_d[d*4 +: 4] = value_q[d*4 +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) value_q <= '0;
    else         value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/score_board.sv
// N-player BCD score keeper: point edge detect, win detection, game-over latch with
// winner blink, and active-low 7-segment drive.
module score_board
  import pong_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned BLINK_DIV   = 25_000_000
) (
  input  logic          clk,
  input  logic          resetn,
  score_board_if.slave  sb
);

  localparam int unsigned WW = winner_width(NUM_PLAYERS);
  localparam int unsigned SW = DIGITS * 4;
  localparam int unsigned CW = $clog2(BLINK_DIV);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8) begin : g_bad_players
    $error("score_board: NUM_PLAYERS must be 1..8");
  end
  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("score_board: DIGITS must be 1..4");
  end
  if (WIN_SCORE > 10 ** DIGITS - 1) begin : g_bad_win
    $error("score_board: WIN_SCORE does not fit in DIGITS");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink
    $error("score_board: BLINK_DIV must be >= 2");
  end

  state_e                 state_q, state_d;
  logic [NUM_PLAYERS-1:0] point_q;
  logic [NUM_PLAYERS-1:0] inc;
  logic [NUM_PLAYERS-1:0] cnt_inc;
  logic [NUM_PLAYERS-1:0] hit;
  logic [WW-1:0]          win_idx;
  logic [WW-1:0]          winner_q, winner_d;
  logic [CW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                   blank_q, blank_d;
  logic [SW-1:0]          value [NUM_PLAYERS];

  logic [NUM_PLAYERS*SW-1:0]       scores;
  logic [NUM_PLAYERS*DIGITS*7-1:0] segs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) point_q <= '0;
    else         point_q <= sb.point;
  end

  assign inc = sb.point & ~point_q;
  // Scores only move in PLAY, and a new-game request swallows any same-cycle point.
  assign cnt_inc = (state_q == PLAY && !sb.new_game) ? inc : '0;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    score_bcd_counter #(
      .DIGITS (DIGITS)
    ) u_counter (
      .clk    (clk),
      .resetn (resetn),
      .clr    (sb.new_game),
      .inc    (cnt_inc[g]),
      .value  (value[g])
    );
  end

  // A player wins when the point it scores this cycle lands exactly on WIN_SCORE.
  always_comb begin
    hit     = '0;
    win_idx = '0;
    for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
      if (WIN_SCORE != 0 && cnt_inc[i] && (bcd_to_int(16'(value[i])) + 1 == WIN_SCORE)) begin
        hit[i]  = 1'b1;
        win_idx = WW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    blink_cnt_d = blink_cnt_q;
    blank_d     = blank_q;
    if (sb.new_game) begin
      state_d     = PLAY;
      winner_d    = '0;
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else begin
      unique case (state_q)
        PLAY: begin
          blink_cnt_d = '0;
          blank_d     = 1'b0;
          if (|hit) begin
            state_d  = OVER;
            winner_d = win_idx;
          end
        end
        OVER: begin
          if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blank_d     = ~blank_q;
          end else begin
            blink_cnt_d = blink_cnt_q + CW'(1);
          end
        end
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= PLAY;
      winner_q    <= '0;
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
    end
  end

  always_comb begin
    scores = '0;
    segs   = '0;
    for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
      scores[p*SW +: SW] = value[p];
      for (int d = 0; d < int'(DIGITS); d++) begin
        if (state_q == OVER && blank_q && winner_q == WW'(p)) begin
          segs[(p*DIGITS+d)*7 +: 7] = SEG_BLANK;
        end else begin
          segs[(p*DIGITS+d)*7 +: 7] = bcd_to_seg(value[p][d*4 +: 4]);
        end
      end
    end
  end

  assign sb.gameover = (state_q == OVER);
  assign sb.winner   = (state_q == OVER) ? winner_q : '0;
  assign sb.scores   = scores;
  assign sb.segments = segs;

endmodule

// File: tb/tb_score_board.sv
// Randomised and directed bench for score_board against a decimal-arithmetic game model.
module tb_score_board;

  localparam int A_WIN   = 11;
  localparam int A_BLINK = 4;
  localparam int A_MAX   = 99;
  localparam int B_MAX   = 9;

  logic clk;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  logic [6:0] seg_tab [10] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001,
    7'b001_0010, 7'b000_0010, 7'b111_1000, 7'b000_0000, 7'b001_0000
  };

  score_board_if #(.NUM_PLAYERS(2), .DIGITS(2)) sb_a ();
  score_board_if #(.NUM_PLAYERS(2), .DIGITS(1)) sb_b ();

  score_board #(
    .NUM_PLAYERS (2),
    .DIGITS      (2),
    .WIN_SCORE   (11),
    .BLINK_DIV   (4)
  ) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sb_a)
  );

  score_board #(
    .NUM_PLAYERS (2),
    .DIGITS      (1),
    .WIN_SCORE   (0),
    .BLINK_DIV   (4)
  ) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sb_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Game model: integer scores, time spent in game-over drives the blink phase.
  int       m_score [2];
  logic [1:0] m_prev;
  bit       m_over;
  int       m_win;
  int       m_t;
  int       mb_score [2];
  logic [1:0] mb_prev;

  task automatic model_reset();
    m_score  = '{0, 0};
    m_prev   = '0;
    m_over   = 1'b0;
    m_win    = 0;
    m_t      = 0;
    mb_score = '{0, 0};
    mb_prev  = '0;
  endtask

  task automatic model_step();
    int reached;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (sb_a.new_game) begin
      m_score = '{0, 0};
      m_over  = 1'b0;
      m_win   = 0;
      m_t     = 0;
    end else if (!m_over) begin
      reached = -1;
      for (int i = 0; i < 2; i++) begin
        if (sb_a.point[i] && !m_prev[i]) begin
          if (m_score[i] < A_MAX) m_score[i]++;
          if (m_score[i] == A_WIN && reached < 0) reached = i;
        end
      end
      if (reached >= 0) begin
        m_over = 1'b1;
        m_win  = reached;
        m_t    = 0;
      end
    end else begin
      m_t++;
    end
    m_prev = sb_a.point;
    if (sb_b.new_game) begin
      mb_score = '{0, 0};
    end else begin
      for (int i = 0; i < 2; i++)
        if (sb_b.point[i] && !mb_prev[i] && mb_score[i] < B_MAX) mb_score[i]++;
    end
    mb_prev = sb_b.point;
  endtask

  function automatic logic [15:0] exp_scores_a();
    logic [15:0] r;
    for (int i = 0; i < 2; i++) r[i*8 +: 8] = {4'(m_score[i] / 10), 4'(m_score[i] % 10)};
    return r;
  endfunction

  function automatic logic [27:0] exp_segs_a();
    logic [27:0] r;
    int          dig;
    for (int i = 0; i < 2; i++) begin
      for (int d = 0; d < 2; d++) begin
        dig = (d == 0) ? m_score[i] % 10 : m_score[i] / 10;
        r[(i*2+d)*7 +: 7] = seg_tab[dig];
        if (m_over && ((m_t / A_BLINK) % 2 == 1) && m_win == i) r[(i*2+d)*7 +: 7] = 7'h7F;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_a(input int i);
    sb_a.point[i] = 1'b1;
    tick();
    sb_a.point[i] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    sb_a.point = '0; sb_a.new_game = 1'b0;
    sb_b.point = '0; sb_b.new_game = 1'b0;
    model_reset();
    #12;
    checks++;
    if (sb_a.scores !== 16'h0000) begin
      failures++; $display("FAIL reset_scores got=%h exp=0000", sb_a.scores);
    end
    checks++;
    if (sb_a.segments !== {4{7'h40}}) begin
      failures++; $display("FAIL reset_segments got=%h exp=%h", sb_a.segments, {4{7'h40}});
    end
    checks++;
    if (sb_a.gameover !== 1'b0 || sb_a.winner !== 1'b0) begin
      failures++; $display("FAIL reset_status got=%b/%b exp=0/0", sb_a.gameover, sb_a.winner);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_count();
    sb_a.point[0] = 1'b1;
    tick();
    checks++;
    if (sb_a.scores[7:0] !== 8'h01) begin
      failures++; $display("FAIL count_latency got=%h exp=01", sb_a.scores[7:0]);
    end
    sb_a.point[0] = 1'b0;
    tick();
    pulse_a(0);
    pulse_a(0);
    checks++;
    if (sb_a.scores[7:0] !== 8'h03) begin
      failures++; $display("FAIL count_three got=%h exp=03", sb_a.scores[7:0]);
    end
    checks++;
    if (sb_a.segments[6:0] !== 7'b011_0000 || sb_a.segments[13:7] !== 7'b100_0000) begin
      failures++; $display("FAIL count_segs got=%h exp=%h", sb_a.segments[13:0], 14'h2030);
    end
    checks++;
    if (sb_a.gameover !== 1'b0) begin
      failures++; $display("FAIL count_gameover got=%b exp=0", sb_a.gameover);
    end
  endtask

  task automatic test_hold_and_carry();
    sb_a.point[1] = 1'b1;
    repeat (10) tick();
    sb_a.point[1] = 1'b0;
    tick();
    checks++;
    if (sb_a.scores[15:8] !== 8'h01) begin
      failures++; $display("FAIL hold_once got=%h exp=01", sb_a.scores[15:8]);
    end
    repeat (9) pulse_a(1);
    checks++;
    if (sb_a.scores[15:8] !== 8'h10) begin
      failures++; $display("FAIL bcd_carry got=%h exp=10", sb_a.scores[15:8]);
    end
    checks++;
    if (sb_a.segments[27:14] !== {7'h79, 7'h40}) begin
      failures++; $display("FAIL carry_segs got=%h exp=%h", sb_a.segments[27:14], {7'h79, 7'h40});
    end
  endtask

  task automatic test_win();
    repeat (7) pulse_a(0);
    checks++;
    if (sb_a.scores !== 16'h1010 || sb_a.gameover !== 1'b0) begin
      failures++; $display("FAIL pre_win got=%h/%b exp=1010/0", sb_a.scores, sb_a.gameover);
    end
    sb_a.point = 2'b11;
    tick();
    sb_a.point = 2'b00;
    checks++;
    if (sb_a.scores !== 16'h1111) begin
      failures++; $display("FAIL win_scores got=%h exp=1111", sb_a.scores);
    end
    checks++;
    if (sb_a.gameover !== 1'b1 || sb_a.winner !== 1'b0) begin
      failures++; $display("FAIL win_status got=%b/%b exp=1/0", sb_a.gameover, sb_a.winner);
    end
    tick();
    pulse_a(0);
    pulse_a(1);
    checks++;
    if (sb_a.scores !== 16'h1111 || sb_a.gameover !== 1'b1) begin
      failures++; $display("FAIL over_frozen got=%h/%b exp=1111/1", sb_a.scores, sb_a.gameover);
    end
  endtask

  task automatic test_blink_and_new_game();
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (sb_a.segments !== exp_segs_a()) begin
        failures++; $display("FAIL blink_segs got=%h exp=%h", sb_a.segments, exp_segs_a());
      end
      checks++;
      if (sb_a.segments[27:14] !== {7'h79, 7'h79}) begin
        failures++; $display("FAIL loser_steady got=%h exp=%h", sb_a.segments[27:14], {7'h79, 7'h79});
      end
    end
    sb_a.point    = 2'b10;
    sb_a.new_game = 1'b1;
    tick();
    sb_a.new_game = 1'b0;
    checks++;
    if (sb_a.scores !== 16'h0000 || sb_a.gameover !== 1'b0 || sb_a.winner !== 1'b0) begin
      failures++;
      $display("FAIL new_game got=%h/%b/%b exp=0000/0/0", sb_a.scores, sb_a.gameover, sb_a.winner);
    end
    tick();
    checks++;
    if (sb_a.scores !== 16'h0000) begin
      failures++; $display("FAIL held_after_new_game got=%h exp=0000", sb_a.scores);
    end
    sb_a.point = 2'b00;
    tick();
    pulse_a(1);
    checks++;
    if (sb_a.scores !== 16'h0100) begin
      failures++; $display("FAIL point_after_new_game got=%h exp=0100", sb_a.scores);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      sb_a.point    = 2'($urandom_range(0, 3));
      sb_a.new_game = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (sb_a.scores !== exp_scores_a()) begin
        failures++; $display("FAIL rnd_scores cyc=%0d got=%h exp=%h", k, sb_a.scores, exp_scores_a());
      end
      checks++;
      if (sb_a.segments !== exp_segs_a()) begin
        failures++; $display("FAIL rnd_segs cyc=%0d got=%h exp=%h", k, sb_a.segments, exp_segs_a());
      end
      checks++;
      if (sb_a.gameover !== m_over || sb_a.winner !== (m_over ? 1'(m_win) : 1'b0)) begin
        failures++;
        $display("FAIL rnd_status cyc=%0d got=%b/%b exp=%b/%0d", k, sb_a.gameover, sb_a.winner,
                 m_over, m_win);
      end
    end
    sb_a.point    = '0;
    sb_a.new_game = 1'b0;
    tick();
  endtask

  task automatic test_free_play();
    logic seen_go;
    seen_go = 1'b0;
    for (int k = 0; k < 12; k++) begin
      sb_b.point[0] = 1'b1;
      tick();
      seen_go |= sb_b.gameover;
      sb_b.point[0] = 1'b0;
      tick();
      seen_go |= sb_b.gameover;
    end
    checks++;
    if (sb_b.scores !== 8'h09) begin
      failures++; $display("FAIL free_saturate got=%h exp=09", sb_b.scores);
    end
    checks++;
    if (sb_b.scores !== {4'(mb_score[1]), 4'(mb_score[0])}) begin
      failures++; $display("FAIL free_model got=%h exp=%0d%0d", sb_b.scores, mb_score[1], mb_score[0]);
    end
    checks++;
    if (sb_b.segments !== {7'h40, 7'h10}) begin
      failures++; $display("FAIL free_segs got=%h exp=%h", sb_b.segments, {7'h40, 7'h10});
    end
    checks++;
    if (seen_go !== 1'b0) begin
      failures++; $display("FAIL free_gameover got=%b exp=0", seen_go);
    end
  endtask

  task automatic test_async_reset();
    sb_a.new_game = 1'b1;
    tick();
    sb_a.new_game = 1'b0;
    repeat (11) pulse_a(0);
    repeat (4) tick();
    checks++;
    if (sb_a.scores !== 16'h0011 || sb_a.gameover !== 1'b1) begin
      failures++; $display("FAIL pre_reset got=%h/%b exp=0011/1", sb_a.scores, sb_a.gameover);
    end
    checks++;
    if (sb_a.segments[13:0] !== 14'h3FFF) begin
      failures++; $display("FAIL pre_reset_blank got=%h exp=3fff", sb_a.segments[13:0]);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (sb_a.scores !== 16'h0000 || sb_a.segments !== {4{7'h40}}) begin
      failures++; $display("FAIL async_clear got=%h/%h exp=0000/%h", sb_a.scores, sb_a.segments,
                           {4{7'h40}});
    end
    checks++;
    if (sb_a.gameover !== 1'b0 || sb_a.winner !== 1'b0 || sb_b.scores !== 8'h00) begin
      failures++; $display("FAIL async_status got=%b/%b/%h exp=0/0/00", sb_a.gameover, sb_a.winner,
                           sb_b.scores);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    pulse_a(1);
    checks++;
    if (sb_a.scores !== 16'h0100 || sb_a.scores !== exp_scores_a()) begin
      failures++; $display("FAIL after_reset got=%h exp=0100", sb_a.scores);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_hold_and_carry();
    test_win();
    test_blink_and_new_game();
    test_random();
    test_free_play();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
